// File: rtl/spi_slave.sv
// SPI mode-0 slave with clk-domain synchronizers, a single-byte transmit buffer
// and a one-cycle rx_valid strobe per completed byte.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       nss,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync, nss_sync, mosi_sync, warm;
    logic                   sclk_s, nss_s, mosi_s, sclk_d, nss_d, nss_arm;
    logic [7:0]             tx_buf, tx_shift, rx_shift;
    logic                   tx_pending, byte_done, done_pend;
    logic [2:0]             bit_cnt;
    logic                   sclk_rise, sclk_fall, nss_rise, nss_fall, load_ok, consume;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign nss_s     = nss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign nss_rise  = nss_s & ~nss_d;
    assign nss_fall  = ~nss_s & nss_d;
    assign load_ok   = tx_load & ~tx_pending;
    assign tx_ready  = ~tx_pending;
    assign busy      = (state == ACTIVE);
    assign miso      = (state == ACTIVE) & tx_shift[7];

    always_comb begin
        consume = 1'b0;
        if (state == IDLE)
            consume = nss_fall & nss_arm;
        else if (!nss_rise && sclk_fall && byte_done)
            consume = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sclk_sync  <= '0;
            mosi_sync  <= '0;
            nss_sync   <= '1;
            warm       <= '0;
            sclk_d     <= 1'b0;
            nss_d      <= 1'b1;
            nss_arm    <= 1'b0;
            tx_buf     <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            tx_pending <= 1'b0;
            byte_done  <= 1'b0;
            done_pend  <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            nss_sync  <= {nss_sync[SYNC_STAGES-2:0], nss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            warm      <= {warm[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            nss_d     <= nss_s;
            // A select already low when reset releases must not start a frame:
            // arm only once nss_s has been seen high with real pin data.
            if (warm[SYNC_STAGES-1] && nss_s)
                nss_arm <= 1'b1;

            rx_valid  <= 1'b0;
            done_pend <= 1'b0;
            if (done_pend) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end

            if (load_ok)
                tx_buf <= tx_data;
            if (load_ok)
                tx_pending <= 1'b1;
            else if (consume)
                tx_pending <= 1'b0;

            case (state)
                IDLE: begin
                    if (nss_fall && nss_arm) begin
                        state     <= ACTIVE;
                        tx_shift  <= tx_pending ? tx_buf : 8'h00;
                        bit_cnt   <= '0;
                        byte_done <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (nss_rise) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        byte_done <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[6:0], mosi_s};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            done_pend <= 1'b1;
                            byte_done <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (byte_done) begin
                            tx_shift  <= tx_pending ? tx_buf : 8'h00;
                            byte_done <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
